// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg: op encoding and chunk-width helpers shared by the pipelined adder
package pipelined_adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic bit chunk_legal(int width, int stages);
        return stages >= 1 && stages <= width && width % stages == 0;
    endfunction

    // Falls back to 1 on an illegal split so elaboration reaches the $error in the top.
    function automatic int chunk_width(int width, int stages);
        return chunk_legal(width, stages) ? width / stages : 1;
    endfunction

endpackage

// File: rtl/pipelined_adder_rca_slice.sv
// rca_slice: combinational W-bit ripple-carry chain.
// Ports: x, y operands; ci carry in; s sum; co carry out; c_msb carry into bit W-1.
module rca_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb
);

    logic [W:0] c;

    always_comb begin
        c[0] = ci;
        s    = '0;
        for (int i = 0; i < W; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign co    = c[W];
    assign c_msb = c[W-1];

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep pipelined ripple-carry adder/subtractor with valid/ready flow control.
// Ports: clk, rst (async, active high); in_valid/in_ready with operands a, b, cin, sub
// (0: a+b+cin, 1: a-b); out_valid/out_ready with results sum, cout, ovf.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (!chunk_legal(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    logic              en;
    logic [WIDTH-1:0]  b_eff;
    logic              c0;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] carry_d, carry_q;
    logic [WIDTH-1:0]  s_d, s_q;
    logic              cmsb_d, cmsb_q;

    // One global enable: the whole pipe moves or the whole pipe holds.
    assign en        = ~out_valid | out_ready;
    assign in_ready  = en;
    assign b_eff     = (sub == OP_ADD) ? b : ~b;
    assign c0        = (sub == OP_SUB) ? 1'b1 : cin;
    assign out_valid = valid_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign ovf       = cmsb_q ^ carry_q[STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            s_q     <= '0;
            cmsb_q  <= 1'b0;
        end else if (en) begin
            valid_q <= (valid_q << 1) | STAGES'(in_valid);
            carry_q <= carry_d;
            s_q     <= s_d;
            cmsb_q  <= cmsb_d;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK-1:0] x, y, s;
        logic             ci, co, cm;

        if (k == 0) begin : g_head
            assign x  = a[CHUNK-1:0];
            assign y  = b_eff[CHUNK-1:0];
            assign ci = c0;
        end else begin : g_skew
            // Operand chunk k waits k cycles so it meets the carry of its own beat.
            logic [CHUNK-1:0] xa_q [k];
            logic [CHUNK-1:0] yb_q [k];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    xa_q <= '{default: '0};
                    yb_q <= '{default: '0};
                end else if (en) begin
                    xa_q[0] <= a[k*CHUNK +: CHUNK];
                    yb_q[0] <= b_eff[k*CHUNK +: CHUNK];
                    for (int j = 1; j < k; j++) begin
                        xa_q[j] <= xa_q[j-1];
                        yb_q[j] <= yb_q[j-1];
                    end
                end
            end
            assign x  = xa_q[k-1];
            assign y  = yb_q[k-1];
            assign ci = carry_q[k-1];
        end

        rca_slice #(.W(CHUNK)) u_rca (
            .x    (x),
            .y    (y),
            .ci   (ci),
            .s    (s),
            .co   (co),
            .c_msb(cm)
        );

        assign s_d[k*CHUNK +: CHUNK] = s;
        assign carry_d[k]            = co;

        if (k == STAGES - 1) begin : g_last
            assign sum[k*CHUNK +: CHUNK] = s_q[k*CHUNK +: CHUNK];
            assign cmsb_d                = cm;
        end else begin : g_deskew
            // Earlier chunks finish early and wait here for the top chunk of the same beat.
            localparam int D = STAGES - 1 - k;
            logic [CHUNK-1:0] d_q [D];
            logic             cm_unused;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    d_q <= '{default: '0};
                end else if (en) begin
                    d_q[0] <= s_q[k*CHUNK +: CHUNK];
                    for (int j = 1; j < D; j++) begin
                        d_q[j] <= d_q[j-1];
                    end
                end
            end
            assign sum[k*CHUNK +: CHUNK] = d_q[D-1];
            assign cm_unused             = cm;
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed and streamed checks of pipelined_adder in 8x2 and 32x4 configurations
module tb_pipelined_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        iv8 = 0, ir8, ov8, ordy8 = 1, cin8 = 0, sub8 = 0, co8, of8;
    logic [7:0]  a8 = 0, b8 = 0, s8;
    logic        iv32 = 0, ir32, ov32, ordy32 = 1, cin32 = 0, sub32 = 0, co32, of32;
    logic [31:0] a32 = 0, b32 = 0, s32;

    int checks = 0;
    int errors = 0;

    pipelined_adder #(.WIDTH(8), .STAGES(2)) u_d8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(ordy8),
        .sum(s8), .cout(co8), .ovf(of8)
    );

    pipelined_adder #(.WIDTH(32), .STAGES(4)) u_d32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(ordy32),
        .sum(s32), .cout(co32), .ovf(of32)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from plain integer arithmetic and sign rules.
    function automatic logic [33:0] model32(logic [31:0] x, logic [31:0] y, logic c, logic s);
        logic [31:0] yy;
        logic [32:0] r;
        logic        o;
        yy = s ? ~y : y;
        r  = {1'b0, x} + {1'b0, yy} + {32'd0, (s ? 1'b1 : c)};
        o  = (x[31] == yy[31]) && (r[31] != x[31]);
        return {o, r};
    endfunction

    task automatic run8(string tag, logic [7:0] ta, logic [7:0] tb, logic tc, logic ts,
                        logic [7:0] es, logic ec, logic eo);
        a8 = ta; b8 = tb; cin8 = tc; sub8 = ts; iv8 = 1; ordy8 = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            iv8 = 0;
            if (i < 1) check({tag, "_early"}, ov8, 0);
        end
        check({tag, "_valid"}, ov8, 1);
        check({tag, "_sum"}, s8, es);
        check({tag, "_cout"}, co8, ec);
        check({tag, "_ovf"}, of8, eo);
    endtask

    task automatic run32(string tag, logic [31:0] ta, logic [31:0] tb, logic tc, logic ts,
                         logic [31:0] es, logic ec, logic eo);
        a32 = ta; b32 = tb; cin32 = tc; sub32 = ts; iv32 = 1; ordy32 = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            iv32 = 0;
            if (i < 3) check({tag, "_early"}, ov32, 0);
        end
        check({tag, "_valid"}, ov32, 1);
        check({tag, "_sum"}, s32, es);
        check({tag, "_cout"}, co32, ec);
        check({tag, "_ovf"}, of32, eo);
    endtask

    task automatic stream32(string tag, int n, bit bp);
        logic [33:0] q[$];
        logic [33:0] e;
        logic [33:0] held;
        int sent = 0, got = 0, cyc = 0;
        bit stalled = 0;
        while (got < n && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                check({tag, "_hold_valid"}, ov32, 1);
                check({tag, "_hold_data"}, {of32, co32, s32}, held);
            end
            ordy32 = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sent < n) begin
                a32 = $urandom; b32 = $urandom;
                cin32 = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1));
                iv32 = 1;
            end else begin
                iv32 = 0;
            end
            #1;
            if (!bp) check({tag, "_in_ready"}, ir32, 1);
            if (ov32 && ordy32) begin
                if (q.size() == 0) begin
                    check({tag, "_spurious"}, 1, 0);
                end else begin
                    e = q.pop_front();
                    check({tag, "_result"}, {of32, co32, s32}, e);
                end
                got++;
            end
            stalled = ov32 && !ordy32;
            held    = {of32, co32, s32};
            if (iv32 && ir32) begin
                q.push_back(model32(a32, b32, cin32, sub32));
                sent++;
            end
        end
        iv32 = 0;
        check({tag, "_count"}, got, n);
        if (!bp) check({tag, "_cycles"}, cyc, n + 4);
        check({tag, "_drained"}, q.size(), 0);
        ordy32 = 1;
    endtask

    initial begin
        #1;
        check("rst8_valid", ov8, 0);
        check("rst8_outs", {s8, co8, of8}, 0);
        check("rst8_in_ready", ir8, 1);
        check("rst32_valid", ov32, 0);
        check("rst32_outs", {s32, co32, of32}, 0);
        check("rst32_in_ready", ir32, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 0;

        run8("add_7f_01", 8'h7F, 8'h01, 0, 0, 8'h80, 0, 1);
        run8("sub_05_07", 8'h05, 8'h07, 0, 1, 8'hFE, 0, 0);
        run8("sub_80_01", 8'h80, 8'h01, 0, 1, 8'h7F, 1, 1);
        run8("add_ff_c1", 8'hFF, 8'h00, 1, 0, 8'h00, 1, 0);
        run8("add_cin_ignored_sub", 8'h10, 8'h10, 1, 1, 8'h00, 1, 0);

        run32("carry_all", 32'hFFFF_FFFF, 32'h0, 1, 0, 32'h0, 1, 0);
        run32("add_ovf32", 32'h7FFF_FFFF, 32'h1, 0, 0, 32'h8000_0000, 0, 1);
        run32("sub_borrow32", 32'h0, 32'h1, 0, 1, 32'hFFFF_FFFF, 0, 0);

        stream32("stream", 100, 0);
        stream32("bp", 200, 1);

        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            a32 = 32'h1111_1111 * (i + 1); b32 = 32'h2; cin32 = 0; sub32 = 0;
            iv32 = 1; ordy32 = 1;
            @(negedge clk);
        end
        iv32 = 0;
        check("pre_rst_valid", ov32, 1);
        #2;
        rst = 1;
        #1;
        check("mid_rst_valid", ov32, 0);
        check("mid_rst_outs", {s32, co32, of32}, 0);
        check("mid_rst_in_ready", ir32, 1);
        @(negedge clk);
        rst = 0;
        run32("post_rst", 32'h1, 32'h2, 0, 0, 32'h3, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
